// File: rtl/system86_timing_pkg.sv
// rtl/system86_timing_pkg.sv - raster constants and helpers for the System86 video timing generator
package system86_timing_pkg;

  // Master clocks per pixel; must stay a power of two so the prescaler wraps naturally
  localparam int CLK_DIV = 8;
  localparam int DIV_W   = $clog2(CLK_DIV);

  // Raster counter widths
  localparam int H_W = 9;
  localparam int V_W = 9;

  // Horizontal raster, in pixels
  localparam int H_TOTAL     = 384;
  localparam int H_VISIBLE   = 288;
  localparam int HSYNC_START = 312;
  localparam int HSYNC_WIDTH = 32;

  // Vertical raster, in lines
  localparam int V_TOTAL     = 264;
  localparam int V_VISIBLE   = 224;
  localparam int VSYNC_START = 240;
  localparam int VSYNC_WIDTH = 8;

  // True when x lies in [start, start+width)
  function automatic logic in_window(input int x, input int start, input int width);
    return (x >= start) && (x < start + width);
  endfunction

endpackage

// File: rtl/timing_counter.sv
// rtl/timing_counter.sv - modulo-N counter with enable, look-ahead next value and wrap pulse
module timing_counter #(
  parameter int N = 384,
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(N - 1));
  assign o_wrap   = i_en && w_at_max;
  assign o_count  = r_count;

  // Value the counter will hold after this edge; decoders look at it so their
  // registered outputs move in the same cycle as the count itself.
  always_comb begin
    o_next = r_count;
    if (i_en) begin
      o_next = w_at_max ? '0 : r_count + W'(1);
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_next;
    end
  end

endmodule

// File: rtl/timing_subsystem.sv
// rtl/timing_subsystem.sv - System86 pixel clock, raster counters, sync/blank and H strobes
module timing_subsystem
  import system86_timing_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_H_VISIBLE   = H_VISIBLE,
  parameter int P_HSYNC_START = HSYNC_START,
  parameter int P_HSYNC_WIDTH = HSYNC_WIDTH,
  parameter int P_V_TOTAL     = V_TOTAL,
  parameter int P_V_VISIBLE   = V_VISIBLE,
  parameter int P_VSYNC_START = VSYNC_START,
  parameter int P_VSYNC_WIDTH = VSYNC_WIDTH
) (
  input  logic CLK_48M,
  input  logic rst_n,
  output logic CLK_6M,
  output logic _1H,
  output logic _2H,
  output logic _4H,
  output logic n1H,
  output logic S1H,
  output logic S2H,
  output logic nS1H,
  output logic _1V,
  output logic _4V,
  output logic _8V,
  output logic nHSYNC,
  output logic nVSYNC,
  output logic nHBLANK,
  output logic nVBLANK,
  output logic nVRESET,
  output logic nCOMPSYNC
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             w_pix_en;
  logic             w_pix_fall;

  logic [H_W-1:0]   w_h;
  logic [H_W-1:0]   w_h_next;
  logic             w_h_wrap;
  logic [V_W-1:0]   w_v;
  logic [V_W-1:0]   w_v_next;
  logic             w_v_wrap;

  logic             w_hs_d;
  logic             w_vs_d;
  logic             w_unused;

  logic r_clk6m;
  logic r_n1h;
  logic r_s1h;
  logic r_s2h;
  logic r_ns1h;
  logic r_hsync_n;
  logic r_vsync_n;
  logic r_hblank_n;
  logic r_vblank_n;
  logic r_vreset_n;
  logic r_csync_n;

  assign w_div_next = r_div + DIV_W'(1);
  assign w_pix_en   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_pix_fall = (r_div == DIV_W'(CLK_DIV / 2 - 1));

  timing_counter #(
    .N(P_H_TOTAL),
    .W(H_W)
  ) u_h_cnt (
    .i_clk   (CLK_48M),
    .i_rst_n (rst_n),
    .i_en    (w_pix_en),
    .o_count (w_h),
    .o_next  (w_h_next),
    .o_wrap  (w_h_wrap)
  );

  timing_counter #(
    .N(P_V_TOTAL),
    .W(V_W)
  ) u_v_cnt (
    .i_clk   (CLK_48M),
    .i_rst_n (rst_n),
    .i_en    (w_h_wrap),
    .o_count (w_v),
    .o_next  (w_v_next),
    .o_wrap  (w_v_wrap)
  );

  // Only the low H/V bits leave the block; frame wrap has no consumer
  assign w_unused = ^{w_h[H_W-1:3], w_v[V_W-1:4], w_v[1], w_v_wrap};

  // Sync decodes of the upcoming count, shared by the sync and composite flops
  assign w_hs_d = ~in_window(int'(w_h_next), P_HSYNC_START, P_HSYNC_WIDTH);
  assign w_vs_d = ~in_window(int'(w_v_next), P_VSYNC_START, P_VSYNC_WIDTH);

  // Prescaler and pixel clock: CLK_6M high for the first half of each pixel
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_clk6m <= 1'b1;
    end else begin
      r_div   <= w_div_next;
      r_clk6m <= ~w_div_next[DIV_W-1];
    end
  end

  // Half-pixel delayed H strobes, captured on the CLK_6M falling edge
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n) begin
      r_s1h  <= 1'b0;
      r_s2h  <= 1'b0;
      r_ns1h <= 1'b1;
    end else if (w_pix_fall) begin
      r_s1h  <= w_h[0];
      r_s2h  <= w_h[1];
      r_ns1h <= ~w_h[0];
    end
  end

  // Raster decodes registered from the next count so they switch with the counters
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n) begin
      r_n1h      <= 1'b1;
      r_hsync_n  <= 1'b1;
      r_vsync_n  <= 1'b1;
      r_hblank_n <= 1'b1;
      r_vblank_n <= 1'b1;
      r_vreset_n <= 1'b1;
      r_csync_n  <= 1'b1;
    end else begin
      r_n1h      <= ~w_h_next[0];
      r_hsync_n  <= w_hs_d;
      r_vsync_n  <= w_vs_d;
      r_hblank_n <= (int'(w_h_next) < P_H_VISIBLE);
      r_vblank_n <= (int'(w_v_next) < P_V_VISIBLE);
      r_vreset_n <= (int'(w_v_next) != P_V_TOTAL - 1);
      r_csync_n  <= w_hs_d & w_vs_d;
    end
  end

  assign CLK_6M    = r_clk6m;
  assign _1H       = w_h[0];
  assign _2H       = w_h[1];
  assign _4H       = w_h[2];
  assign n1H       = r_n1h;
  assign S1H       = r_s1h;
  assign S2H       = r_s2h;
  assign nS1H      = r_ns1h;
  assign _1V       = w_v[0];
  assign _4V       = w_v[2];
  assign _8V       = w_v[3];
  assign nHSYNC    = r_hsync_n;
  assign nVSYNC    = r_vsync_n;
  assign nHBLANK   = r_hblank_n;
  assign nVBLANK   = r_vblank_n;
  assign nVRESET   = r_vreset_n;
  assign nCOMPSYNC = r_csync_n;

endmodule

// File: tb/tb_timing_subsystem.sv
// tb/tb_timing_subsystem.sv - randomized self-checking bench for timing_subsystem against a raster model
module tb_timing_subsystem;

  // Full System86 raster
  localparam int A_HT = 384, A_HV = 288, A_HSS = 312, A_HSW = 32;
  localparam int A_VT = 264, A_VV = 224, A_VSS = 240, A_VSW = 8;
  // Shrunken raster so whole frames fit in a short run
  localparam int B_HT = 24, B_HV = 18, B_HSS = 19, B_HSW = 2;
  localparam int B_VT = 20, B_VV = 14, B_VSS = 15, B_VSW = 2;

  logic clk;
  logic rst_n;

  logic a_clk6m, a_1h, a_2h, a_4h, a_n1h, a_s1h, a_s2h, a_ns1h, a_1v, a_4v, a_8v;
  logic a_nhsync, a_nvsync, a_nhblank, a_nvblank, a_nvreset, a_ncsync;
  logic b_clk6m, b_1h, b_2h, b_4h, b_n1h, b_s1h, b_s2h, b_ns1h, b_1v, b_4v, b_8v;
  logic b_nhsync, b_nvsync, b_nhblank, b_nvblank, b_nvreset, b_ncsync;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;

  int   fall1[4];
  int   fall2[4];
  int   rise1[4];
  logic prev[4];
  logic sig[4];

  timing_subsystem dut_a (
    .CLK_48M(clk), .rst_n(rst_n), .CLK_6M(a_clk6m),
    ._1H(a_1h), ._2H(a_2h), ._4H(a_4h), .n1H(a_n1h),
    .S1H(a_s1h), .S2H(a_s2h), .nS1H(a_ns1h),
    ._1V(a_1v), ._4V(a_4v), ._8V(a_8v),
    .nHSYNC(a_nhsync), .nVSYNC(a_nvsync), .nHBLANK(a_nhblank),
    .nVBLANK(a_nvblank), .nVRESET(a_nvreset), .nCOMPSYNC(a_ncsync)
  );

  timing_subsystem #(
    .P_H_TOTAL(B_HT), .P_H_VISIBLE(B_HV), .P_HSYNC_START(B_HSS), .P_HSYNC_WIDTH(B_HSW),
    .P_V_TOTAL(B_VT), .P_V_VISIBLE(B_VV), .P_VSYNC_START(B_VSS), .P_VSYNC_WIDTH(B_VSW)
  ) dut_b (
    .CLK_48M(clk), .rst_n(rst_n), .CLK_6M(b_clk6m),
    ._1H(b_1h), ._2H(b_2h), ._4H(b_4h), .n1H(b_n1h),
    .S1H(b_s1h), .S2H(b_s2h), .nS1H(b_ns1h),
    ._1V(b_1v), ._4V(b_4v), ._8V(b_8v),
    .nHSYNC(b_nhsync), .nVSYNC(b_nvsync), .nHBLANK(b_nhblank),
    .nVBLANK(b_nvblank), .nVRESET(b_nvreset), .nCOMPSYNC(b_ncsync)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // Expected outputs n master clocks after reset release, from raster arithmetic
  function automatic logic [16:0] model(input int cyc, input int ht, input int hv, input int hss,
                                        input int hsw, input int vt, input int vv, input int vss,
                                        input int vsw);
    int   div, p, h, v, hd;
    logic hs, vs;
    div = cyc % 8;
    p   = cyc / 8;
    h   = p % ht;
    v   = (p / ht) % vt;
    hd  = (((cyc >= 4) ? cyc - 4 : 0) / 8) % ht;
    hs  = !(h >= hss && h < hss + hsw);
    vs  = !(v >= vss && v < vss + vsw);
    return {div < 4, h[0], h[1], h[2], !h[0], hd[0], hd[1], !hd[0], v[0], v[2], v[3],
            hs, vs, h < hv, v < vv, v != vt - 1, hs & vs};
  endfunction

  function automatic logic [16:0] vec_a();
    return {a_clk6m, a_1h, a_2h, a_4h, a_n1h, a_s1h, a_s2h, a_ns1h, a_1v, a_4v, a_8v,
            a_nhsync, a_nvsync, a_nhblank, a_nvblank, a_nvreset, a_ncsync};
  endfunction

  function automatic logic [16:0] vec_b();
    return {b_clk6m, b_1h, b_2h, b_4h, b_n1h, b_s1h, b_s2h, b_ns1h, b_1v, b_4v, b_8v,
            b_nhsync, b_nvsync, b_nhblank, b_nvblank, b_nvreset, b_ncsync};
  endfunction

  task automatic compare(input string tag);
    check_eq({tag, "_a"}, 32'(vec_a()), 32'(model(n, A_HT, A_HV, A_HSS, A_HSW, A_VT, A_VV, A_VSS, A_VSW)));
    check_eq({tag, "_b"}, 32'(vec_b()), 32'(model(n, B_HT, B_HV, B_HSS, B_HSW, B_VT, B_VV, B_VSS, B_VSW)));
  endtask

  task automatic clear_watch();
    for (int k = 0; k < 4; k++) begin
      fall1[k] = -1;
      fall2[k] = -1;
      rise1[k] = -1;
      prev[k]  = 1'b1;
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      if (rst_n) n++;
      @(negedge clk);
      compare("cyc");
      sig[0] = a_nhsync;
      sig[1] = a_nhblank;
      sig[2] = b_nvsync;
      sig[3] = b_nvreset;
      for (int k = 0; k < 4; k++) begin
        if (prev[k] && !sig[k]) begin
          if (fall1[k] < 0) fall1[k] = n;
          else if (fall2[k] < 0) fall2[k] = n;
        end
        if (!prev[k] && sig[k] && fall1[k] >= 0 && rise1[k] < 0) rise1[k] = n;
        prev[k] = sig[k];
      end
    end
  endtask

  task automatic do_reset(input int hold);
    #3 rst_n = 1'b0;
    n = 0;
    #1 compare("rst_imm");
    repeat (hold) begin
      @(negedge clk);
      compare("rst_hold");
    end
    #2 rst_n = 1'b1;
    clear_watch();
  endtask

  initial begin
    int target;
    rst_n = 1'b0;
    clear_watch();
    repeat (5) begin
      @(negedge clk);
      compare("rst_init");
    end
    #2 rst_n = 1'b1;

    run(9300 + int'($urandom_range(0, 300)));
    check_eq("a_hs_fall",  32'(fall1[0]), 32'(312 * 8));
    check_eq("a_line",     32'(fall2[0] - fall1[0]), 32'(3072));
    check_eq("a_hs_low",   32'(rise1[0] - fall1[0]), 32'(256));
    check_eq("a_hb_fall",  32'(fall1[1]), 32'(288 * 8));
    check_eq("a_hb_low",   32'(rise1[1] - fall1[1]), 32'(96 * 8));
    check_eq("b_vs_fall",  32'(fall1[2]), 32'(B_VSS * B_HT * 8));
    check_eq("b_frame",    32'(fall2[2] - fall1[2]), 32'(B_VT * B_HT * 8));
    check_eq("b_vs_low",   32'(rise1[2] - fall1[2]), 32'(B_VSW * B_HT * 8));
    check_eq("b_vr_fall",  32'(fall1[3]), 32'((B_VT - 1) * B_HT * 8));
    check_eq("b_vr_low",   32'(rise1[3] - fall1[3]), 32'(B_HT * 8));

    // Reset in the middle of a frame of the small raster, near V=10, H=12
    target = (n / (B_VT * B_HT * 8) + 1) * (B_VT * B_HT * 8) + (10 * B_HT + 12) * 8
             + int'($urandom_range(0, 7));
    run(target - n);
    do_reset(int'($urandom_range(1, 12)));
    run(2700 + int'($urandom_range(0, 200)));
    check_eq("a_hs_fall_rst", 32'(fall1[0]), 32'(312 * 8));
    check_eq("a_hb_fall_rst", 32'(fall1[1]), 32'(288 * 8));

    // A few short randomly placed resets
    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(5, 600)));
      do_reset(int'($urandom_range(1, 6)));
    end
    run(int'($urandom_range(50, 400)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
